// File: rtl/d_cache_wb2way.sv
// 2-way set-associative write-back/write-allocate data cache between the core data port and the sram-like bridge.
// Hits complete combinationally; misses write back then refill line-wise. Optional counters: D_CACHE_PERF_EN.
module d_cache_wb2way #(
  parameter int INDEX_WIDTH = 7,
  parameter int LINE_WORDS  = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cpu_data_req,
  input  logic        cpu_data_wr,
  input  logic [1:0]  cpu_data_size,
  input  logic [31:0] cpu_data_addr,
  input  logic [31:0] cpu_data_wdata,
  output logic [31:0] cpu_data_rdata,
  output logic        cpu_data_addr_ok,
  output logic        cpu_data_data_ok,
  output logic        cache_data_req,
  output logic        cache_data_wr,
  output logic [1:0]  cache_data_size,
  output logic [31:0] cache_data_addr,
  output logic [31:0] cache_data_wdata,
  input  logic [31:0] cache_data_rdata,
  input  logic        cache_data_addr_ok,
  input  logic        cache_data_data_ok
`ifdef D_CACHE_PERF_EN
  ,
  output logic [31:0] perf_hit_cnt,
  output logic [31:0] perf_miss_cnt,
  output logic [31:0] perf_wb_cnt
`endif
);
  localparam int WORD_BITS    = $clog2(LINE_WORDS);
  localparam int OFFSET_WIDTH = WORD_BITS + 2;
  localparam int TAG_WIDTH    = 32 - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int SETS         = 1 << INDEX_WIDTH;
  localparam int DEPTH        = SETS * LINE_WORDS;

  typedef enum logic [1:0] {IDLE, WB, REFILL, RESP} state_t;

  logic [31:0]          data_mem [2][DEPTH];
  logic [TAG_WIDTH-1:0] tag_mem  [2][SETS];
  logic [1:0][SETS-1:0] valid, dirty;
  logic [SETS-1:0]      lru;

  state_t               state;
  logic [WORD_BITS-1:0] cnt;
  logic                 addr_acc;
  logic                 victim;
  logic [31:0]          lat_addr, lat_wdata;
  logic                 lat_wr;
  logic [1:0]           lat_size;

  logic [TAG_WIDTH-1:0]   c_tag, l_tag;
  logic [INDEX_WIDTH-1:0] c_idx, l_idx;
  logic [WORD_BITS-1:0]   c_word, l_word;
  logic hit0, hit1, hit_way, idle_req, idle_hit, idle_miss, new_victim;
  logic mem_active, word_done;
  logic [31:0] hit_word, resp_word, wb_word;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [1:0] size, input logic [1:0] a);
    logic [3:0]  m;
    logic [31:0] r;
    case (size)
      2'b00:   m = 4'b0001 << a;
      2'b01:   m = a[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = m[i] ? wd[i*8 +: 8] : old[i*8 +: 8];
    return r;
  endfunction

  assign c_tag  = cpu_data_addr[31 -: TAG_WIDTH];
  assign c_idx  = cpu_data_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign c_word = cpu_data_addr[2 +: WORD_BITS];
  assign l_tag  = lat_addr[31 -: TAG_WIDTH];
  assign l_idx  = lat_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign l_word = lat_addr[2 +: WORD_BITS];

  assign hit0       = valid[0][c_idx] && (tag_mem[0][c_idx] == c_tag);
  assign hit1       = valid[1][c_idx] && (tag_mem[1][c_idx] == c_tag);
  assign hit_way    = hit1;
  assign idle_req   = (state == IDLE) && cpu_data_req;
  assign idle_hit   = idle_req && (hit0 || hit1);
  assign idle_miss  = idle_req && !(hit0 || hit1);
  assign new_victim = !valid[0][c_idx] ? 1'b0 : (!valid[1][c_idx] ? 1'b1 : lru[c_idx]);

  assign hit_word  = data_mem[hit_way][{c_idx, c_word}];
  assign resp_word = data_mem[victim][{l_idx, l_word}];
  assign wb_word   = data_mem[victim][{l_idx, cnt}];

  // A word completes on data_ok, whether its address was accepted earlier or in the same cycle.
  assign mem_active = (state == WB) || (state == REFILL);
  assign word_done  = mem_active && (addr_acc || cache_data_addr_ok) && cache_data_data_ok;

  assign cpu_data_addr_ok = resetn && idle_req;
  assign cpu_data_data_ok = resetn && (idle_hit || (state == RESP));
  assign cpu_data_rdata   = !resetn ? 32'h0 : (state == RESP) ? resp_word : idle_hit ? hit_word : 32'h0;
  assign cache_data_req   = resetn && mem_active && !addr_acc;
  assign cache_data_wr    = resetn && (state == WB);
  assign cache_data_size  = resetn ? 2'b10 : 2'b00;
  assign cache_data_addr  = !resetn ? 32'h0 :
                            {(state == WB) ? tag_mem[victim][l_idx] : l_tag, l_idx, cnt, 2'b00};
  assign cache_data_wdata = (resetn && (state == WB)) ? wb_word : 32'h0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_acc  <= 1'b0;
      victim    <= 1'b0;
      valid     <= '0;
      dirty     <= '0;
      lru       <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wr    <= 1'b0;
      lat_size  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (idle_hit) begin
            lru[c_idx] <= ~hit_way;
            if (cpu_data_wr) dirty[hit_way][c_idx] <= 1'b1;
          end else if (idle_miss) begin
            lat_addr  <= cpu_data_addr;
            lat_wdata <= cpu_data_wdata;
            lat_wr    <= cpu_data_wr;
            lat_size  <= cpu_data_size;
            victim    <= new_victim;
            cnt       <= '0;
            addr_acc  <= 1'b0;
            state     <= (valid[new_victim][c_idx] && dirty[new_victim][c_idx]) ? WB : REFILL;
          end
        end
        WB, REFILL: begin
          if (word_done) begin
            addr_acc <= 1'b0;
            cnt      <= cnt + 1'b1;
            if (&cnt) begin
              if (state == WB) begin
                state <= REFILL;
              end else begin
                state                <= RESP;
                valid[victim][l_idx] <= 1'b1;
                dirty[victim][l_idx] <= 1'b0;
              end
            end
          end else if (cache_data_addr_ok && !addr_acc) begin
            addr_acc <= 1'b1;
          end
        end
        RESP: begin
          state      <= IDLE;
          lru[l_idx] <= ~victim;
          if (lat_wr) dirty[victim][l_idx] <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (idle_hit && cpu_data_wr)
      data_mem[hit_way][{c_idx, c_word}] <= merge(hit_word, cpu_data_wdata, cpu_data_size, cpu_data_addr[1:0]);
    if ((state == REFILL) && word_done)
      data_mem[victim][{l_idx, cnt}] <= cache_data_rdata;
    if ((state == REFILL) && word_done && (&cnt))
      tag_mem[victim][l_idx] <= l_tag;
    if ((state == RESP) && lat_wr)
      data_mem[victim][{l_idx, l_word}] <= merge(resp_word, lat_wdata, lat_size, lat_addr[1:0]);
  end

`ifdef D_CACHE_PERF_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_hit_cnt  <= '0;
      perf_miss_cnt <= '0;
      perf_wb_cnt   <= '0;
    end else begin
      if (idle_hit)  perf_hit_cnt  <= perf_hit_cnt + 32'd1;
      if (idle_miss) perf_miss_cnt <= perf_miss_cnt + 32'd1;
      if ((state == WB) && word_done && (&cnt)) perf_wb_cnt <= perf_wb_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_d_cache_wb2way.sv
// Randomized bench for d_cache_wb2way: flat CPU-view memory plus a set/way occupancy model predict hits and bus traffic.
module tb_d_cache_wb2way;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cpu_data_req = 1'b0;
  logic        cpu_data_wr = 1'b0;
  logic [1:0]  cpu_data_size = 2'b10;
  logic [31:0] cpu_data_addr = 32'h0;
  logic [31:0] cpu_data_wdata = 32'h0;
  logic [31:0] cpu_data_rdata;
  logic        cpu_data_addr_ok, cpu_data_data_ok;
  logic        cache_data_req, cache_data_wr;
  logic [1:0]  cache_data_size;
  logic [31:0] cache_data_addr, cache_data_wdata;
  logic [31:0] cache_data_rdata = 32'h0;
  logic        cache_data_addr_ok = 1'b0;
  logic        cache_data_data_ok = 1'b0;
`ifdef D_CACHE_PERF_EN
  logic [31:0] perf_hit_cnt, perf_miss_cnt, perf_wb_cnt;
`endif

  d_cache_wb2way dut (
    .clk(clk), .resetn(resetn),
    .cpu_data_req(cpu_data_req), .cpu_data_wr(cpu_data_wr), .cpu_data_size(cpu_data_size),
    .cpu_data_addr(cpu_data_addr), .cpu_data_wdata(cpu_data_wdata), .cpu_data_rdata(cpu_data_rdata),
    .cpu_data_addr_ok(cpu_data_addr_ok), .cpu_data_data_ok(cpu_data_data_ok),
    .cache_data_req(cache_data_req), .cache_data_wr(cache_data_wr), .cache_data_size(cache_data_size),
    .cache_data_addr(cache_data_addr), .cache_data_wdata(cache_data_wdata), .cache_data_rdata(cache_data_rdata),
    .cache_data_addr_ok(cache_data_addr_ok), .cache_data_data_ok(cache_data_data_ok)
`ifdef D_CACHE_PERF_EN
    , .perf_hit_cnt(perf_hit_cnt), .perf_miss_cnt(perf_miss_cnt), .perf_wb_cnt(perf_wb_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Backing memory (slave side) and CPU-visible memory (what loads must return).
  logic [31:0] smem [logic [31:0]];
  logic [31:0] rmem [logic [31:0]];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h13572468;
  endfunction
  function automatic logic [31:0] s_get(input logic [31:0] a);
    return smem.exists(a) ? smem[a] : init_val(a);
  endfunction
  function automatic logic [31:0] r_get(input logic [31:0] a);
    return rmem.exists(a) ? rmem[a] : init_val(a);
  endfunction
  function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] wd,
                                            input logic [1:0] size, input logic [1:0] off);
    logic [31:0] r;
    int lo, n;
    r  = old;
    n  = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    lo = (size == 2'b10) ? 0 : int'(off);
    for (int b = lo; b < lo + n; b++) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  // Cache occupancy model: 128 sets x 2 ways, victim pointer per set.
  logic [31:0] m_tag [128][2];
  bit          m_val [128][2];
  bit          m_dirty [128][2];
  int          m_lru [128];
  int          m_hit = 0, m_miss = 0, m_wb = 0;

  task automatic model_clear();
    for (int s = 0; s < 128; s++) begin
      m_lru[s] = 0;
      for (int w = 0; w < 2; w++) begin m_val[s][w] = 0; m_dirty[s][w] = 0; m_tag[s][w] = '0; end
    end
    m_hit = 0; m_miss = 0; m_wb = 0;
  endtask

  // Bus traffic log written by the memory slave.
  bit          lg_wr [$];
  logic [31:0] lg_addr [$];
  logic [31:0] lg_dat [$];
  logic [1:0]  lg_size [$];

  task automatic log_clear();
    lg_wr.delete(); lg_addr.delete(); lg_dat.delete(); lg_size.delete();
  endtask

  bit          s_busy = 0;
  int          s_dly = 0;
  bit          s_wr = 0;
  logic [31:0] s_addr = 0, s_wdata = 0;
  logic [1:0]  s_size = 0;

  task automatic s_complete();
    cache_data_data_ok = 1'b1;
    if (s_wr) smem[s_addr] = s_wdata;
    else      cache_data_rdata = s_get(s_addr);
    lg_wr.push_back(s_wr);
    lg_addr.push_back(s_addr);
    lg_dat.push_back(s_wr ? s_wdata : cache_data_rdata);
    lg_size.push_back(s_size);
  endtask

  always @(negedge clk or negedge resetn) begin
    if (!resetn) begin
      cache_data_addr_ok = 1'b0; cache_data_data_ok = 1'b0; s_busy = 0;
    end else begin
      cache_data_addr_ok = 1'b0; cache_data_data_ok = 1'b0;
      if (s_busy) begin
        if (s_dly == 0) begin s_complete(); s_busy = 0; end
        else s_dly--;
      end else if (cache_data_req && $urandom_range(0, 3) != 0) begin
        cache_data_addr_ok = 1'b1;
        s_wr = cache_data_wr; s_addr = cache_data_addr; s_wdata = cache_data_wdata; s_size = cache_data_size;
        s_dly = $urandom_range(0, 2);
        if (s_dly == 0) s_complete();
        else begin s_busy = 1; s_dly--; end
      end
    end
  end

  task automatic do_op(input bit wr, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata, input string name);
    int set, hw, vw;
    bit hit, got;
    logic [31:0] tag, la, a, exp_word;
    bit          e_wr [$];
    logic [31:0] e_addr [$];
    logic [31:0] e_dat [$];
    set = int'((addr >> 4) & 32'h7F);
    tag = addr >> 11;
    la  = {addr[31:2], 2'b00};
    hit = 0; hw = 0;
    for (int w = 0; w < 2; w++) if (m_val[set][w] && m_tag[set][w] == tag) begin hit = 1; hw = w; end
    if (!hit) begin
      vw = !m_val[set][0] ? 0 : (!m_val[set][1] ? 1 : m_lru[set]);
      if (m_val[set][vw] && m_dirty[set][vw]) begin
        for (int k = 0; k < 4; k++) begin
          a = (m_tag[set][vw] << 11) | (32'(set) << 4) | (32'(k) << 2);
          e_wr.push_back(1); e_addr.push_back(a); e_dat.push_back(r_get(a));
        end
        m_wb++;
      end
      for (int k = 0; k < 4; k++) begin
        a = (tag << 11) | (32'(set) << 4) | (32'(k) << 2);
        e_wr.push_back(0); e_addr.push_back(a); e_dat.push_back(s_get(a));
      end
      m_val[set][vw] = 1; m_tag[set][vw] = tag; m_dirty[set][vw] = wr; hw = vw;
      m_miss++;
    end else begin
      if (wr) m_dirty[set][hw] = 1;
      m_hit++;
    end
    m_lru[set] = 1 - hw;
    exp_word = r_get(la);
    if (wr) rmem[la] = ref_merge(exp_word, wdata, size, addr[1:0]);
    log_clear();

    @(negedge clk);
    cpu_data_req = 1; cpu_data_wr = wr; cpu_data_size = size; cpu_data_addr = addr; cpu_data_wdata = wdata;
    #1;
    checks++;
    if (cpu_data_addr_ok !== 1'b1) begin failures++; $display("FAIL %s addr_ok got=%b exp=1", name, cpu_data_addr_ok); end
    checks++;
    if (cpu_data_data_ok !== hit) begin failures++; $display("FAIL %s same_cycle_data_ok got=%b exp=%b", name, cpu_data_data_ok, hit); end
    if (hit && !wr) begin
      checks++;
      if (cpu_data_rdata !== exp_word) begin failures++; $display("FAIL %s hit_rdata got=%h exp=%h", name, cpu_data_rdata, exp_word); end
    end
    @(posedge clk);
    @(negedge clk);
    cpu_data_req = 0; cpu_data_wr = 0;
    if (!hit) begin
      got = 0;
      for (int c = 0; c < 400 && !got; c++) begin
        if (c > 0) @(negedge clk);
        #1;
        if (cpu_data_data_ok === 1'b1) got = 1;
      end
      checks++;
      if (!got) begin failures++; $display("FAIL %s miss_data_ok got=timeout exp=1", name); end
      else if (!wr) begin
        checks++;
        if (cpu_data_rdata !== exp_word) begin failures++; $display("FAIL %s miss_rdata got=%h exp=%h", name, cpu_data_rdata, exp_word); end
      end
      @(posedge clk);
    end
    checks++;
    if (lg_addr.size() != e_addr.size()) begin
      failures++; $display("FAIL %s traffic_count got=%0d exp=%0d", name, lg_addr.size(), e_addr.size());
    end else begin
      for (int i = 0; i < e_addr.size(); i++) begin
        checks++;
        if (lg_wr[i] !== e_wr[i] || lg_addr[i] !== e_addr[i] || lg_dat[i] !== e_dat[i] || lg_size[i] !== 2'b10) begin
          failures++;
          $display("FAIL %s traffic[%0d] got wr=%0d addr=%h dat=%h size=%b exp wr=%0d addr=%h dat=%h size=10",
                   name, i, lg_wr[i], lg_addr[i], lg_dat[i], lg_size[i], e_wr[i], e_addr[i], e_dat[i]);
        end
      end
    end
  endtask

  function automatic logic [101:0] all_outs();
    return {cpu_data_rdata, cpu_data_addr_ok, cpu_data_data_ok, cache_data_req, cache_data_wr,
            cache_data_size, cache_data_addr, cache_data_wdata};
  endfunction

  task automatic test_reset();
    model_clear();
    cpu_data_req = 1; cpu_data_addr = 32'h0000_1000;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (all_outs() !== '0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", all_outs()); end
    cpu_data_req = 0;
    @(negedge clk); resetn = 1;
    @(negedge clk); #1;
    checks++;
    if ({cpu_data_addr_ok, cpu_data_data_ok, cache_data_req} !== 3'b000) begin
      failures++; $display("FAIL post_reset_idle got=%b exp=000", {cpu_data_addr_ok, cpu_data_data_ok, cache_data_req});
    end
  endtask

  task automatic test_cold_load();
    do_op(0, 2'b10, 32'h0000_1004, 32'h0, "cold_load");
    do_op(0, 2'b10, 32'h0000_1008, 32'h0, "line_hit");
  endtask

  task automatic test_store_hit();
    do_op(1, 2'b00, 32'h0000_1001, 32'h0000_AB00, "store_byte_hit");
    do_op(0, 2'b10, 32'h0000_1000, 32'h0, "load_merged");
    do_op(1, 2'b01, 32'h0000_100E, 32'hBEEF_0000, "store_half_hi");
    do_op(0, 2'b10, 32'h0000_100C, 32'h0, "load_half_hi");
  endtask

  task automatic test_evict();
    do_op(0, 2'b10, 32'h0000_1800, 32'h0, "fill_way1");
    do_op(0, 2'b10, 32'h0000_2000, 32'h0, "dirty_evict");
    do_op(0, 2'b10, 32'h0000_1800, 32'h0, "survivor_hit");
  endtask

  task automatic test_store_miss();
    do_op(1, 2'b10, 32'h0000_3004, 32'hDEAD_BEEF, "store_miss");
    do_op(0, 2'b10, 32'h0000_3004, 32'h0, "store_miss_readback");
  endtask

  task automatic test_reset_mid_refill();
    logic [31:0] a;
    a = 32'h0000_5014;
    log_clear();
    @(negedge clk);
    cpu_data_req = 1; cpu_data_wr = 0; cpu_data_size = 2'b10; cpu_data_addr = a;
    @(posedge clk);
    @(negedge clk); cpu_data_req = 0;
    #1;
    for (int c = 0; c < 200 && lg_addr.size() < 2; c++) begin @(negedge clk); #1; end
    checks++;
    if (lg_addr.size() != 2) begin failures++; $display("FAIL mid_refill_progress got=%0d exp=2", lg_addr.size()); end
    #1 resetn = 0;
    #1;
    checks++;
    if (all_outs() !== '0) begin failures++; $display("FAIL async_reset_outputs got=%h exp=0", all_outs()); end
    repeat (2) @(negedge clk);
    resetn = 1;
    model_clear();
    rmem = smem;
    log_clear();
`ifdef D_CACHE_PERF_EN
    #1;
    checks++;
    if ({perf_hit_cnt, perf_miss_cnt, perf_wb_cnt} !== 96'h0) begin
      failures++; $display("FAIL perf_after_reset got=%h/%h/%h exp=0", perf_hit_cnt, perf_miss_cnt, perf_wb_cnt);
    end
`endif
    do_op(0, 2'b10, a, 32'h0, "refill_after_reset");
  endtask

  task automatic test_random();
    logic [31:0] addr;
    logic [1:0]  size;
    bit          wr;
    for (int n = 0; n < 300; n++) begin
      size = 2'($urandom_range(0, 2));
      wr   = 1'($urandom_range(0, 1));
      addr = (32'($urandom_range(1, 5)) << 11) | (32'($urandom_range(0, 2)) << 4) | (32'($urandom_range(0, 3)) << 2);
      if (size == 2'b00) addr[1:0] = 2'($urandom_range(0, 3));
      if (size == 2'b01) addr[1]   = 1'($urandom_range(0, 1));
      do_op(wr, size, addr, $urandom, "random");
    end
  endtask

`ifdef D_CACHE_PERF_EN
  task automatic test_perf();
    #1;
    checks++;
    if (perf_hit_cnt !== 32'(m_hit)) begin failures++; $display("FAIL perf_hit got=%0d exp=%0d", perf_hit_cnt, m_hit); end
    checks++;
    if (perf_miss_cnt !== 32'(m_miss)) begin failures++; $display("FAIL perf_miss got=%0d exp=%0d", perf_miss_cnt, m_miss); end
    checks++;
    if (perf_wb_cnt !== 32'(m_wb)) begin failures++; $display("FAIL perf_wb got=%0d exp=%0d", perf_wb_cnt, m_wb); end
    @(negedge clk); resetn = 0; #1;
    checks++;
    if ({perf_hit_cnt, perf_miss_cnt, perf_wb_cnt} !== 96'h0) begin
      failures++; $display("FAIL perf_reset got=%h/%h/%h exp=0", perf_hit_cnt, perf_miss_cnt, perf_wb_cnt);
    end
    @(negedge clk); resetn = 1;
  endtask
`endif

  initial begin
    smem[32'h1000] = 32'h1122_3344; smem[32'h1004] = 32'hA1A1_0001;
    smem[32'h1008] = 32'hA2A2_0002; smem[32'h100C] = 32'hA3A3_0003;
    rmem = smem;
    test_reset();
    test_cold_load();
    test_store_hit();
    test_evict();
    test_store_miss();
    test_reset_mid_refill();
    test_random();
`ifdef D_CACHE_PERF_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
